// File: rtl/mux2_rr_arbiter.sv
// ============================================================================
//  Module   : mux2_rr_arbiter
//  Brief    : Two-input round-robin arbiter feeding a single registered output
//             slot. Optional per-requester beat counters via MUX2_ARB_STATS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux2_rr_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a_valid,
   input  logic [WIDTH-1:0] a_data,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [WIDTH-1:0] b_data,
   output logic             b_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_src,
   input  logic             out_ready
`ifdef MUX2_ARB_STATS_EN
   ,
   output logic [7:0]       cnt_a,
   output logic [7:0]       cnt_b
`endif
);

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      HOLD_A = 2'd1,
      HOLD_B = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             src_q, src_d;
   logic             prio_q, prio_d;

   logic             slot_free;
   logic             grant_a;
   logic             grant_b;

   always_comb begin
      slot_free = (state_q == EMPTY) || out_ready;
      grant_a   = a_valid && (!b_valid || (prio_q == 1'b0));
      grant_b   = b_valid && (!a_valid || (prio_q == 1'b1));
      // Readies are masked during reset so nothing looks accepted then.
      a_ready   = rst_n && slot_free && grant_a;
      b_ready   = rst_n && slot_free && grant_b;
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      src_d   = src_q;
      prio_d  = prio_q;
      if (a_ready) begin
         state_d = HOLD_A;
         data_d  = a_data;
         src_d   = 1'b0;
         prio_d  = 1'b1;
      end else if (b_ready) begin
         state_d = HOLD_B;
         data_d  = b_data;
         src_d   = 1'b1;
         prio_d  = 1'b0;
      end else if ((state_q != EMPTY) && out_ready) begin
         // Drain with no refill: payload and source stay as last presented.
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         data_q  <= '0;
         src_q   <= 1'b0;
         prio_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         src_q   <= src_d;
         prio_q  <= prio_d;
      end
   end

   assign out_valid = (state_q != EMPTY);
   assign out_data  = data_q;
   assign out_src   = src_q;

`ifdef MUX2_ARB_STATS_EN
   logic [7:0] cnt_a_q, cnt_a_d;
   logic [7:0] cnt_b_q, cnt_b_d;

   always_comb begin
      cnt_a_d = cnt_a_q;
      cnt_b_d = cnt_b_q;
      if (a_ready) cnt_a_d = cnt_a_q + 8'd1;
      if (b_ready) cnt_b_d = cnt_b_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_a_q <= 8'd0;
         cnt_b_q <= 8'd0;
      end else begin
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
      end
   end

   assign cnt_a = cnt_a_q;
   assign cnt_b = cnt_b_q;
`else
   // Statistics build option disabled: no counter logic present.
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
// ============================================================================
//  Module   : tb_mux2_rr_arbiter
//  Brief    : Directed self-checking bench for mux2_rr_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux2_rr_arbiter;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             a_valid;
   logic [WIDTH-1:0] a_data;
   logic             a_ready;
   logic             b_valid;
   logic [WIDTH-1:0] b_data;
   logic             b_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_src;
   logic             out_ready;
`ifdef MUX2_ARB_STATS_EN
   logic [7:0]       cnt_a;
   logic [7:0]       cnt_b;
`endif

   int n_cmp;
   int n_bad;

   mux2_rr_arbiter #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_valid   (a_valid),
      .a_data    (a_data),
      .a_ready   (a_ready),
      .b_valid   (b_valid),
      .b_data    (b_data),
      .b_ready   (b_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
`ifdef MUX2_ARB_STATS_EN
      ,
      .cnt_a     (cnt_a),
      .cnt_b     (cnt_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past one rising edge; inputs change and outputs are sampled 1ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      a_valid   = 1'b0;
      b_valid   = 1'b0;
      a_data    = '0;
      b_data    = '0;
      out_ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      a_valid   = 1'b1;
      b_valid   = 1'b1;
      a_data    = 8'h11;
      b_data    = 8'h22;
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_out_valid cyc%0d: got %b want 0", i, out_valid);
         end
         n_cmp++;
         if (out_data !== 8'h00) begin
            n_bad++; $display("FAIL reset_out_data cyc%0d: got %h want 00", i, out_data);
         end
         n_cmp++;
         if ({a_ready, b_ready} !== 2'b00) begin
            n_bad++; $display("FAIL reset_ready cyc%0d: got %b want 00", i, {a_ready, b_ready});
         end
      end
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if ({a_ready, b_ready} !== 2'b10) begin
         n_bad++; $display("FAIL reset_first_grant: got %b want 10", {a_ready, b_ready});
      end
      step();
      n_cmp++;
      if ({out_valid, out_src, out_data} !== {1'b1, 1'b0, 8'h11}) begin
         n_bad++; $display("FAIL reset_first_beat: got v%b s%b d%h want v1 s0 d11",
                           out_valid, out_src, out_data);
      end
   endtask

   task automatic test_alternation();
      logic [7:0] exp_d [4];
      logic       exp_s [4];
      exp_d = '{8'h11, 8'h22, 8'h11, 8'h22};
      exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
      do_reset();
      a_valid   = 1'b1;
      b_valid   = 1'b1;
      a_data    = 8'h11;
      b_data    = 8'h22;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_cmp++;
         if ({out_valid, out_src, out_data} !== {1'b1, exp_s[i], exp_d[i]}) begin
            n_bad++; $display("FAIL alternation beat%0d: got v%b s%b d%h want v1 s%b d%h",
                              i, out_valid, out_src, out_data, exp_s[i], exp_d[i]);
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      a_valid   = 1'b1;
      a_data    = 8'hA5;
      out_ready = 1'b1;
      step();
      a_valid   = 1'b0;
      b_valid   = 1'b1;
      b_data    = 8'h5A;
      out_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (b_ready !== 1'b0) begin
            n_bad++; $display("FAIL stall_b_ready cyc%0d: got %b want 0", i, b_ready);
         end
         step();
         n_cmp++;
         if ({out_valid, out_src, out_data} !== {1'b1, 1'b0, 8'hA5}) begin
            n_bad++; $display("FAIL stall_hold cyc%0d: got v%b s%b d%h want v1 s0 dA5",
                              i, out_valid, out_src, out_data);
         end
      end
      out_ready = 1'b1;
      #1;
      n_cmp++;
      if (b_ready !== 1'b1) begin
         n_bad++; $display("FAIL stall_release_b_ready: got %b want 1", b_ready);
      end
      step();
      n_cmp++;
      if ({out_valid, out_src, out_data} !== {1'b1, 1'b1, 8'h5A}) begin
         n_bad++; $display("FAIL stall_release_beat: got v%b s%b d%h want v1 s1 d5A",
                           out_valid, out_src, out_data);
      end
   endtask

   task automatic test_lone_requester();
      do_reset();
      b_valid   = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         b_data = 8'(i);
         #1;
         n_cmp++;
         if (b_ready !== 1'b1) begin
            n_bad++; $display("FAIL lone_b_ready beat%0d: got %b want 1", i, b_ready);
         end
         step();
         n_cmp++;
         if ({out_valid, out_src, out_data} !== {1'b1, 1'b1, 8'(i)}) begin
            n_bad++; $display("FAIL lone_beat%0d: got v%b s%b d%h want v1 s1 d%h",
                              i, out_valid, out_src, out_data, 8'(i));
         end
      end
   endtask

   task automatic test_drain();
      do_reset();
      b_valid   = 1'b1;
      b_data    = 8'h77;
      out_ready = 1'b1;
      step();
      b_valid = 1'b0;
      step();
      n_cmp++;
      if ({out_valid, out_src, out_data} !== {1'b0, 1'b1, 8'h77}) begin
         n_bad++; $display("FAIL drain: got v%b s%b d%h want v0 s1 d77",
                           out_valid, out_src, out_data);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      a_valid   = 1'b1;
      a_data    = 8'h3C;
      out_ready = 1'b1;
      step();
      a_valid   = 1'b0;
      out_ready = 1'b0;
      step();
      n_cmp++;
      if ({out_valid, out_data} !== {1'b1, 8'h3C}) begin
         n_bad++; $display("FAIL midreset_held: got v%b d%h want v1 d3C", out_valid, out_data);
      end
      rst_n = 1'b0;
      step();
      n_cmp++;
      if ({out_valid, out_data} !== {1'b0, 8'h00}) begin
         n_bad++; $display("FAIL midreset_cleared: got v%b d%h want v0 d00", out_valid, out_data);
      end
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL midreset_replay cyc%0d: got v%b d%h want v0",
                              i, out_valid, out_data);
         end
      end
   endtask

`ifdef MUX2_ARB_STATS_EN
   task automatic test_stats();
      do_reset();
      a_valid   = 1'b1;
      a_data    = 8'h01;
      out_ready = 1'b1;
      for (int i = 0; i < 257; i++) step();
      a_valid = 1'b0;
      #1;
      n_cmp++;
      if ({cnt_a, cnt_b} !== {8'd1, 8'd0}) begin
         n_bad++; $display("FAIL stats_wrap: got a%0d b%0d want a1 b0", cnt_a, cnt_b);
      end
   endtask
`endif

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      rst_n     = 1'b0;
      a_valid   = 1'b0;
      b_valid   = 1'b0;
      a_data    = '0;
      b_data    = '0;
      out_ready = 1'b0;
      test_reset();
      test_alternation();
      test_stall();
      test_lone_requester();
      test_drain();
      test_reset_mid();
`ifdef MUX2_ARB_STATS_EN
      test_stats();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mux2_rr_arbiter.md
MUX2_RR_ARBITER -- requirements
Module: mux2_rr_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data width of both requester channels and the output channel.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port a_valid, input, 1 bit: requester A offers a_data.
REQ-005 SHALL have port a_data, input, WIDTH bits: requester A payload.
REQ-006 SHALL have port a_ready, output, 1 bit: A's beat is accepted this cycle.
REQ-007 SHALL have ports b_valid, b_data and b_ready, with the same directions, widths and meanings as the A ports, for requester B.
REQ-008 SHALL have port out_valid, output, 1 bit: the output register holds a beat.
REQ-009 SHALL have port out_data, output, WIDTH bits: the registered muxed payload.
REQ-010 SHALL have port out_src, output, 1 bit: source of the held beat, 0 for A and 1 for B.
REQ-011 SHALL have port out_ready, input, 1 bit: the downstream consumer takes the beat.

Function
REQ-012 SHALL define slot_free = !out_valid || out_ready.
REQ-013 SHALL keep a 1-bit priority pointer prio, where 0 means A is preferred and 1 means B is preferred.
REQ-014 SHALL compute grant_a = a_valid && (!b_valid || prio==0), and grant_b = b_valid && (!a_valid || prio==1).
REQ-015 SHALL drive a_ready = slot_free && grant_a and b_ready = slot_free && grant_b combinationally; they are never both 1 in the same cycle.
REQ-016 SHALL, on an edge where X_ready=1 (X is A or B): load out_data with X_data, set out_src to X, set out_valid to 1, and set prio to the other requester; latency is one cycle from acceptance.
REQ-017 SHALL, on an edge where out_valid && out_ready and no requester is accepted, clear out_valid; out_data and out_src hold their values.
REQ-018 SHALL, while out_valid && !out_ready, hold out_data, out_src and out_valid stable and drive a_ready = b_ready = 0 (stall).
REQ-019 SHALL operate as a state machine with three states: EMPTY (out_valid=0), HOLD_A (out_valid=1, out_src=0) and HOLD_B (out_valid=1, out_src=1).
REQ-020 SHALL take these transitions: to HOLD_A on A acceptance, to HOLD_B on B acceptance, to EMPTY on drain without acceptance, and remain in the current state otherwise.
REQ-021 SHALL, on simultaneous drain and acceptance (out_ready=1 with X_ready=1), replace the held beat with X_data in the same edge, sustaining full throughput of one beat per cycle.
REQ-022 SHALL leave prio unchanged when no requester is accepted, with no starvation: under continuous contention the grants strictly alternate A, B, A, B, and so on.
REQ-023 SHALL let a single active requester win every slot regardless of prio.

Reset
REQ-024 SHALL, when rst_n=0 at a clock edge, set out_valid=0, out_data=0, out_src=0 and prio=0.
REQ-025 SHALL drive a_ready=0 and b_ready=0 during any cycle in which rst_n=0.
REQ-026 SHALL discard a held beat on reset mid-operation; the beat is not replayed after reset.

Configuration
REQ-027 SHALL, when macro MUX2_ARB_STATS_EN is defined, add output ports cnt_a and cnt_b (8 bits each), counting accepted beats per requester.
REQ-028 SHALL, with MUX2_ARB_STATS_EN defined, increment the counter on each acceptance, wrap from 255 to 0, and reset the counters to 0.
REQ-029 SHALL, when MUX2_ARB_STATS_EN is undefined, omit cnt_a, cnt_b and the counter logic entirely; all other behaviour is identical.

Verification
REQ-030 SHALL cover reset: hold rst_n=0 for 2 cycles with a_valid=b_valid=1, then release -> out_valid=0, a_ready=b_ready=0 during reset; first grant after release goes to A.
REQ-031 SHALL cover alternation: a_valid=b_valid=1 with a_data=8'h11, b_data=8'h22 and out_ready=1 for 4 cycles -> out_data sequence 11, 22, 11, 22 and out_src sequence 0, 1, 0, 1.
REQ-032 SHALL cover stall: accept a_data=8'hA5, then hold out_ready=0 for 3 cycles while b_valid=1 -> out_data stays A5 and b_ready=0; when out_ready=1, b_ready=1 in that same cycle.
REQ-033 SHALL cover a lone requester: only b_valid=1 with b_data incrementing 0..5 and out_ready=1 -> out_data sequence 0..5 and out_src=1 throughout.
REQ-034 SHALL cover reset mid-operation: out_valid=1 holding 8'h3C with out_ready=0, pulse rst_n low for 1 cycle -> out_valid=0, out_data=0, and the 3C beat is never presented again.
REQ-035 SHALL cover the stats counters: with MUX2_ARB_STATS_EN defined, accept 257 A beats -> cnt_a=1 and cnt_b=0.
